mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. It consumes the EX result
//  (ALU result used as the address, regB used as store data, funct3 giving the access size).
//  It runs a valid/ready request and response handshake to data memory, aligns and extends
//  load data, and presents a registered write-back result. It stalls upstream while an access
//  is outstanding and times out hung responses.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in WAIT before the access is aborted with error; 0 = no timeout
// PORTS
//  clk                 in   1   system clock, all state on posedge
//  rst                 in   1   asynchronous, active-low reset
//  ex_mem_valid_inst   in   1   valid instruction from EX
//  ex_mem_rd_mem       in   1   instruction is a load
//  ex_mem_wr_mem       in   1   instruction is a store (wins if both set)
//  ex_mem_funct3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_mem_alu_result   in   32  address (mem ops) or pass-through result
//  ex_mem_regb         in   32  store data
//  ex_mem_dest_reg     in   5   destination register index
//  mem_req_valid       out  1   memory request valid
//  mem_req_ready       in   1   memory accepts request
//  mem_req_addr        out  32  word-aligned address {addr[31:2],2'b00}
//  mem_req_we          out  1   1 = store
//  mem_req_wdata       out  32  store data, lane-replicated
//  mem_req_be          out  4   byte enables
//  mem_rsp_valid       in   1   load data valid (one-cycle pulse)
//  mem_rsp_rdata       in   32  load data word
//  mem_stall           out  1   upstream must hold its inputs stable
//  mem_wb_valid        out  1   write-back result valid (one-cycle pulse)
//  mem_wb_result       out  32  aligned/extended load data or pass-through result
//  mem_wb_dest_reg     out  5   destination register; 0 for stores and errors
//  mem_wb_error        out  1   access aborted (timeout or misalign)
//  mem_wb_misalign     out  1   abort cause is misalignment
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, timeout counter 0, every output 0.
//    An in-flight request is dropped and any later response is ignored.
//  - FSM states: IDLE, REQ, WAIT.
//  - IDLE, valid non-memory instruction: one cycle later mem_wb_valid=1, result=alu_result,
//    dest=dest_reg. No stall.
//  - IDLE, valid load or store: latch operands, go to REQ. mem_stall=1 in REQ and WAIT only.
//  - REQ: mem_req_valid=1, with addr/we/wdata/be held stable until mem_req_ready.
//    Transfer happens on the cycle where valid and ready are both 1.
//    - Store: next state IDLE; next cycle mem_wb_valid=1, dest=0.
//    - Load: next state WAIT, counter cleared.
//  - WAIT: counter increments each cycle.
//    - mem_rsp_valid: next cycle mem_wb_valid=1 with the aligned result; next state IDLE.
//    - Counter reaches TIMEOUT_CYCLES-1 with no response: next cycle mem_wb_valid=1,
//      mem_wb_error=1, result=32'hbaadbeef, dest=0; next state IDLE.
//    - Response and timeout in the same cycle: the response wins.
//  - mem_rsp_valid outside WAIT is ignored.
//  - Byte enables: B 4'b0001<<a[1:0]; H 4'b0011<<{a[1],1'b0}; W 4'b1111.
//  - Store data: B {4{b[7:0]}}; H {2{b[15:0]}}; W b.
//  - Load data: word = rdata >> (8*a[1:0]). B/H sign-extend; BU/HU zero-extend.
//    Undefined funct3 values are treated as W.
//  - Throughput: non-memory op 1/cycle; store >=2 cycles; load >=3 cycles.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//    - Misaligned accesses trap: H/HU/SH with a[0]=1, or W/SW with a[1:0]!=0.
//    - No request is issued and there is no stall.
//    - Next cycle: mem_wb_valid=1, mem_wb_error=1, mem_wb_misalign=1, dest=0, result=32'hbaadbeef.
//  MEM_MISALIGN_TRAP_EN undefined:
//    - Low address bits beyond the access size are ignored: H uses a[1], W uses the aligned word.
//    - mem_wb_misalign tied to 0.
// TESTING
//  - Non-memory op, alu_result=32'h1234, dest=5 -> next cycle wb_valid=1, result=32'h1234, dest=5, stall=0.
//  - SB addr=32'h103, regb=32'hAB -> req_addr=32'h100, be=4'b1000, wdata=32'hABABABAB;
//    ready held 0 for 3 cycles -> req stable, stall=1; wb_valid pulses once after the handshake.
//  - LB addr=32'h102, rdata=32'h00800000 two cycles after accept -> result=32'hFFFFFF80;
//    LBU at the same address -> result=32'h00000080.
//  - Load, TIMEOUT_CYCLES=4, no response -> wb_error=1, result=32'hbaadbeef, state IDLE;
//    a late rsp_valid afterwards is ignored.
//  - rst=0 asserted while in WAIT -> all outputs 0 immediately; a response after rst=1 is ignored.
//  - With MEM_MISALIGN_TRAP_EN, LW addr=32'h102 -> no req_valid, wb_error=1, wb_misalign=1 next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Handshake: a request transfers on the cycle where mem_req_valid and mem_req_ready
// are both 1; while mem_req_valid=1 and mem_req_ready=0 the master holds
// mem_req_addr/we/wdata/be stable and does not withdraw mem_req_valid.
// mem_rsp_valid is a one-cycle pulse with no back-pressure; the master only
// takes it while it is waiting for load data and ignores it otherwise.
interface mem_stage_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues load/store requests to data memory,
// aligns/extends load data, passes non-memory results through, and presents a
// registered write-back result. Hung load responses abort after TIMEOUT_CYCLES.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned H/W accesses trap
// instead of silently ignoring the low address bits.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_regb,
  input  logic [4:0]  ex_mem_dest_reg,
  mem_stage_if.master mem,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_dest_reg,
  output logic        mem_wb_error,
  output logic        mem_wb_misalign,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RESULT = 32'hbaadbeef;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{b[7:0]}};
      2'b01:   d = {2{b[15:0]}};
      default: d = b;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend by funct3.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   sh = rdata >> {a, 3'b000};
      2'b01:   sh = rdata >> {a[1], 4'b0000};
      default: sh = rdata;
    endcase
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start;
  logic          misalign_in;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic [4:0]    dest_q;

  logic          wb_valid_d;
  logic [31:0]   wb_result_d;
  logic [4:0]    wb_dest_d;
  logic          wb_error_d;
  logic          wb_misalign_d;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_in = misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // Request bus is driven only in REQ and reads as zero otherwise.
  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_req_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_req_we    = (state_q == REQ) ? we_q : 1'b0;
  assign mem.mem_req_wdata = (state_q == REQ) ? wdata_q : 32'h0;
  assign mem.mem_req_be    = (state_q == REQ) ? be_q : 4'h0;

  assign mem_stall = (state_q != IDLE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, timeout counter and next write-back record.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start         = 1'b0;
    wb_valid_d    = 1'b0;
    wb_result_d   = 32'h0;
    wb_dest_d     = 5'd0;
    wb_error_d    = 1'b0;
    wb_misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_valid_inst) begin
          if (ex_mem_rd_mem || ex_mem_wr_mem) begin
            if (misalign_in) begin
              wb_valid_d    = 1'b1;
              wb_result_d   = ERR_RESULT;
              wb_error_d    = 1'b1;
              wb_misalign_d = 1'b1;
            end else begin
              start   = 1'b1;
              state_d = REQ;
            end
          end else begin
            wb_valid_d  = 1'b1;
            wb_result_d = ex_mem_alu_result;
            wb_dest_d   = ex_mem_dest_reg;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the timeout cycle still wins.
        if (mem.mem_rsp_valid) begin
          wb_valid_d  = 1'b1;
          wb_result_d = load_align(f3_q, addr_q[1:0], mem.mem_rsp_rdata);
          wb_dest_d   = dest_q;
          state_d     = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          wb_valid_d  = 1'b1;
          wb_result_d = ERR_RESULT;
          wb_error_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, timeout counter and registered write-back outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q           <= '0;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      be_q            <= 4'h0;
      f3_q            <= 3'h0;
      we_q            <= 1'b0;
      dest_q          <= 5'd0;
      mem_wb_valid    <= 1'b0;
      mem_wb_result   <= 32'h0;
      mem_wb_dest_reg <= 5'd0;
      mem_wb_error    <= 1'b0;
      mem_wb_misalign <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start) begin
        addr_q  <= ex_mem_alu_result;
        wdata_q <= store_data(ex_mem_funct3, ex_mem_regb);
        be_q    <= byte_en(ex_mem_funct3, ex_mem_alu_result[1:0]);
        f3_q    <= ex_mem_funct3;
        we_q    <= ex_mem_wr_mem;
        dest_q  <= ex_mem_dest_reg;
      end
      mem_wb_valid    <= wb_valid_d;
      mem_wb_result   <= wb_result_d;
      mem_wb_dest_reg <= wb_dest_d;
      mem_wb_error    <= wb_error_d;
      mem_wb_misalign <= wb_misalign_d;
    end
  end

endmodule
